// File: rtl/alarm_beeper.sv
// Alarm buzzer driver: patterned 1 kHz tone with dismiss, ring timeout and,
// when ALARM_BEEPER_SNOOZE_EN is defined, a limited number of snoozes.
module alarm_beeper #(
  parameter int CLK_HZ      = 10000,
  parameter int TONE_HZ     = 1000,
  parameter int BEEP_ON_MS  = 200,
  parameter int BEEP_OFF_MS = 200,
  parameter int TIMEOUT_S   = 60,
  parameter int SNOOZE_S    = 300,
  parameter int MAX_SNOOZE  = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       alarm_match,
  input  logic       dismiss,
  input  logic       snooze,
  output logic       buzzer,
  output logic       ringing,
  output logic       snoozing,
  output logic [1:0] snooze_cnt
);
  localparam int HALF    = CLK_HZ / (2 * TONE_HZ);
  localparam int ON_CYC  = CLK_HZ * BEEP_ON_MS / 1000;
  localparam int PAT_CYC = CLK_HZ * (BEEP_ON_MS + BEEP_OFF_MS) / 1000;
  localparam int SEC_MAX = (TIMEOUT_S > SNOOZE_S) ? TIMEOUT_S : SNOOZE_S;
  localparam int PS_W    = $clog2(CLK_HZ + 1);
  localparam int SEC_W   = $clog2(SEC_MAX + 1);
  localparam int PAT_W   = $clog2(PAT_CYC + 1);
  localparam int DIV_W   = $clog2(HALF + 1);

  typedef enum logic [1:0] {
    IDLE,
    RING,
    DONE
`ifdef ALARM_BEEPER_SNOOZE_EN
    , SNOOZE
`endif
  } state_t;

  state_t             state, state_n;
  logic               match_q, prev_q, dismiss_q, snooze_q;
  logic [1:0]         cnt_q, cnt_n;
  logic [PS_W-1:0]    ps;
  logic [SEC_W-1:0]   sec;
  logic [PAT_W-1:0]   pat, pat_n;
  logic [DIV_W-1:0]   div, div_n;
  logic               phase, phase_n;
  logic               buzzer_q, buzzer_d;
  logic               rise, tick, timer_enter, ring_enter;

  assign rise = match_q & ~prev_q;
  assign tick = (ps == PS_W'(CLK_HZ - 1));

`ifdef ALARM_BEEPER_SNOOZE_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      snooze_q <= 1'b0;
      cnt_q    <= 2'd0;
    end else begin
      snooze_q <= snooze;
      cnt_q    <= cnt_n;
    end
  end
  assign snoozing   = (state == SNOOZE);
  assign snooze_cnt = cnt_q;
`else
  logic unused_snooze;
  assign unused_snooze = snooze | (MAX_SNOOZE == 0);
  assign snooze_q   = 1'b0;
  assign cnt_q      = 2'd0;
  assign snoozing   = 1'b0;
  assign snooze_cnt = 2'd0;
`endif

  always_comb begin
    state_n = state;
    cnt_n   = cnt_q;
    case (state)
      IDLE: begin
        cnt_n = 2'd0;
        if (rise) state_n = RING;
      end
      RING: begin
        // dismiss outranks snooze; dismiss with timeout lands in DONE either way
        if (dismiss_q) state_n = DONE;
`ifdef ALARM_BEEPER_SNOOZE_EN
        else if (snooze_q) begin
          if (cnt_q < 2'(MAX_SNOOZE)) begin
            state_n = SNOOZE;
            cnt_n   = cnt_q + 2'd1;
          end else begin
            state_n = DONE;
          end
        end
`endif
        else if (tick && sec == SEC_W'(TIMEOUT_S - 1)) state_n = DONE;
      end
`ifdef ALARM_BEEPER_SNOOZE_EN
      SNOOZE: begin
        if (dismiss_q) state_n = DONE;
        else if (tick && sec == SEC_W'(SNOOZE_S - 1)) state_n = RING;
      end
`endif
      DONE: if (!match_q) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  assign ring_enter = (state_n == RING) && (state != RING);
`ifdef ALARM_BEEPER_SNOOZE_EN
  assign timer_enter = ring_enter || ((state_n == SNOOZE) && (state != SNOOZE));
`else
  assign timer_enter = ring_enter;
`endif

  // pattern/tone restart on each RING entry so the first half-cycle is high
  always_comb begin
    pat_n   = pat;
    div_n   = div;
    phase_n = phase;
    if (ring_enter) begin
      pat_n   = '0;
      div_n   = '0;
      phase_n = 1'b1;
    end else begin
      pat_n = (pat == PAT_W'(PAT_CYC - 1)) ? '0 : pat + PAT_W'(1);
      if (div == DIV_W'(HALF - 1)) begin
        div_n   = '0;
        phase_n = ~phase;
      end else begin
        div_n = div + DIV_W'(1);
      end
    end
    buzzer_d = (state_n == RING) && (pat_n < PAT_W'(ON_CYC)) && phase_n;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      match_q   <= 1'b0;
      prev_q    <= 1'b0;
      dismiss_q <= 1'b0;
      ps        <= '0;
      sec       <= '0;
      pat       <= '0;
      div       <= '0;
      phase     <= 1'b0;
      buzzer_q  <= 1'b0;
    end else begin
      state     <= state_n;
      match_q   <= alarm_match;
      prev_q    <= match_q;
      dismiss_q <= dismiss;
      if (timer_enter || tick) ps <= '0;
      else                     ps <= ps + PS_W'(1);
      if (timer_enter) sec <= '0;
      else if (tick)   sec <= sec + SEC_W'(1);
      pat       <= pat_n;
      div       <= div_n;
      phase     <= phase_n;
      buzzer_q  <= buzzer_d;
    end
  end

  assign buzzer  = buzzer_q;
  assign ringing = (state == RING);
endmodule

// File: tb/tb_alarm_beeper.sv
// Scoreboard bench for alarm_beeper: expected {buzzer,ringing,snoozing,snooze_cnt}
// are queued per cycle when stimulus is driven and compared at the falling edge.
module tb_alarm_beeper;
  logic       clk = 1'b0;
  logic       rst_n, alarm_match, dismiss, snooze;
  logic       buzzer, ringing, snoozing;
  logic [1:0] snooze_cnt;

  alarm_beeper #(.TIMEOUT_S(2), .SNOOZE_S(1)) dut (
    .clk(clk), .rst_n(rst_n), .alarm_match(alarm_match), .dismiss(dismiss),
    .snooze(snooze), .buzzer(buzzer), .ringing(ringing), .snoozing(snoozing),
    .snooze_cnt(snooze_cnt)
  );

  always #5 clk = ~clk;

  typedef struct { int at; string tag; logic [4:0] v; } exp_t;
  exp_t sb[$];
  int   cyc = 0;
  int   n_chk = 0, n_fail = 0;
  logic [4:0] obs;
  assign obs = {buzzer, ringing, snoozing, snooze_cnt};

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(string tag, logic [31:0] got, logic [31:0] want);
    n_chk++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got %0h want %0h", tag, cyc, got, want);
    end
  endtask

  task automatic push(int at, string tag, logic [4:0] v);
    exp_t e;
    int i;
    e.at = at; e.tag = tag; e.v = v;
    i = sb.size();
    while (i > 0 && sb[i-1].at > at) i--;
    sb.insert(i, e);
  endtask

  always @(negedge clk) begin
    exp_t e;
    while (sb.size() != 0 && sb[0].at <= cyc) begin
      e = sb.pop_front();
      if (e.at < cyc) check({e.tag, "_missed"}, 1, 0);
      else            check(e.tag, {27'd0, obs}, {27'd0, e.v});
    end
  end

  function automatic logic patbz(int k);
    return ((k % 4000) < 2000) && ((k % 10) < 5);
  endfunction

  task automatic wait_until(int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse(logic d, logic s);
    dismiss = d;
    snooze  = s;
    @(posedge clk);
    #1;
    dismiss = 1'b0;
    snooze  = 1'b0;
  endtask

  task automatic ring_start(output int r);
    int t;
    t = cyc;
    alarm_match = 1'b1;
    push(t + 1, "pre_ring", 5'b00000);
    push(t + 2, "ring_on", 5'b11000);
    r = t + 2;
  endtask

  task automatic release_match();
    alarm_match = 1'b0;
    wait_until(cyc + 6);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not end within time budget");
    $fatal(1);
  end

  initial begin
    int r, s;
    rst_n = 1'b0; alarm_match = 1'b0; dismiss = 1'b0; snooze = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_outs", {27'd0, obs}, 0);
    rst_n = 1'b1;
    wait_until(cyc + 2);

    // ring pattern, then async reset mid-ring
    ring_start(r);
    for (int k = 1; k < 4400; k++) push(r + k, "pattern", {patbz(k), 1'b1, 1'b0, 2'b00});
    wait_until(r + 4450);
    rst_n = 1'b0;
    #1;
    check("reset_mid_ring", {27'd0, obs}, 0);
    alarm_match = 1'b0;
    push(r + 4452, "in_reset", 5'b00000);
    wait_until(r + 4455);
    rst_n = 1'b1;
    wait_until(cyc + 4);

    // dismiss, no re-trigger while match held, re-ring after a new edge
    ring_start(r);
    wait_until(r + 8);
    push(r + 9, "dis_hold", 5'b01000);
    push(r + 10, "dis_done", 5'b00000);
    pulse(1'b1, 1'b0);
    for (int j = 1; j <= 10; j++) push(r + 10 + 100 * j, "no_retrig", 5'b00000);
    wait_until(r + 1100);
    release_match();
    ring_start(r);
    wait_until(r + 8);
    push(r + 10, "dis2_done", 5'b00000);
    pulse(1'b1, 1'b0);
    release_match();

    // ring timeout with match held and no buttons
    ring_start(r);
    push(r + 19999, "to_hold", {patbz(19999), 1'b1, 1'b0, 2'b00});
    push(r + 20000, "timeout", 5'b00000);
    wait_until(r + 20005);
    release_match();

`ifdef ALARM_BEEPER_SNOOZE_EN
    ring_start(r);
    for (int i = 1; i <= 3; i++) begin
      wait_until(r + 8);
      push(r + 9, "sn_hold", {3'b010, 2'(i - 1)});
      push(r + 10, "sn_enter", {3'b001, 2'(i)});
      pulse(1'b0, 1'b1);
      s = r + 10;
      r = s + 10000;
      push(r - 1, "sn_wait", {3'b001, 2'(i)});
      push(r, "sn_return", {3'b110, 2'(i)});
      push(r + 5, "sn_tone_lo", {3'b010, 2'(i)});
      if (i == 1) begin
        wait_until(s + 100);
        push(s + 102, "sn_ignored", {3'b001, 2'(i)});
        pulse(1'b0, 1'b1);
      end
    end
    wait_until(r + 8);
    push(r + 9, "sn4_hold", 5'b01011);
    push(r + 10, "sn4_dismiss", 5'b00011);
    pulse(1'b0, 1'b1);
    wait_until(r + 12);
    alarm_match = 1'b0;
    push(r + 16, "cnt_clear", 5'b00000);
    wait_until(r + 20);

    ring_start(r);
    wait_until(r + 8);
    push(r + 10, "sn_enter2", 5'b00101);
    pulse(1'b0, 1'b1);
    wait_until(r + 50);
    push(r + 52, "sn_dismiss", 5'b00001);
    pulse(1'b1, 1'b0);
    release_match();
`else
    ring_start(r);
    wait_until(r + 8);
    push(r + 10, "sn_off_ring", 5'b11000);
    push(r + 11, "sn_off_ring2", 5'b11000);
    pulse(1'b0, 1'b1);
    wait_until(r + 20);
    push(r + 22, "sn_off_dis", 5'b00000);
    pulse(1'b1, 1'b0);
    release_match();
`endif

    // dismiss and snooze together: dismiss wins, count untouched
    ring_start(r);
    wait_until(r + 8);
    push(r + 9, "both_hold", 5'b01000);
    push(r + 10, "both_done", 5'b00000);
    pulse(1'b1, 1'b1);
    release_match();

    wait_until(cyc + 5);
    check("sb_drain", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
